// File: rtl/clock_mode_fsm.sv
// clock_mode_fsm: two-button watch mode controller driving timekeeping, alarm-set and stopwatch datapaths.
module clock_mode_fsm #(
  parameter int TICK_DIV     = 20000000,
  parameter int REPEAT_TICKS = 4,
  parameter int RING_SEC     = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b0,
  input  logic       b1,
  input  logic       tc_sec,
  input  logic       tc_min,
  input  logic       stopwatch_tc,
  input  logic       sec_tick,
  input  logic       alarm_match,
  output logic       en_sec,
  output logic       en_min,
  output logic       en_hour,
  output logic       add_hour,
  output logic       add_min,
  output logic       sel_alarm,
  output logic       stopwatch,
  output logic       stop_enable_sec,
  output logic       stop_enable_min,
  output logic       sw_clear,
  output logic       lap_hold,
  output logic       alarm_armed,
  output logic       alarm_ring,
  output logic [5:0] state
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(REPEAT_TICKS + 1);
  localparam int RW = $clog2(RING_SEC + 1);
  typedef enum logic [5:0] {
    S_WATCH = 6'd1, S_SET = 6'd4, S_SET_MIN = 6'd5, S_SET_HOUR = 6'd6,
    S_ALARM = 6'd8, S_AL_MIN = 6'd9, S_AL_HOUR = 6'd10,
    S_SW = 6'd16, S_SW_STOP = 6'd17, S_SW_RUN = 6'd18, S_SW_LAP = 6'd19
  } state_t;
  state_t        state_q;
  logic [1:0]    b0_sync_q, b1_sync_q;
  logic          b0_smp_q, b1_smp_q, match_q;
  logic [TW-1:0] tick_q;
  logic [HW-1:0] hold_q;
  logic [RW-1:0] ring_cnt_q;
  logic          armed_q, ring_q, add_hour_q, add_min_q, sw_clear_q;
  logic          tick, press0, press1_raw, press1, held0, rep0, inc0, consume, rise, ring_done, edit;
  assign tick       = tick_q == TW'(TICK_DIV - 1);
  assign press0     = tick & ~b0_sync_q[1] & b0_smp_q;
  assign press1_raw = tick & ~b1_sync_q[1] & b1_smp_q;
  assign press1     = press1_raw & ~press0;
  assign held0      = tick & ~b0_sync_q[1] & ~b0_smp_q;
  assign rep0       = held0 & (hold_q >= HW'(REPEAT_TICKS - 1));
  assign inc0       = press0 | rep0;
  // a press that silences the ringer does nothing else
  assign consume    = ring_q & (press0 | press1_raw);
  assign rise       = alarm_match & ~match_q;
  assign ring_done  = sec_tick & (ring_cnt_q == RW'(RING_SEC - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b0_sync_q  <= 2'b11;
      b1_sync_q  <= 2'b11;
      b0_smp_q   <= 1'b1;
      b1_smp_q   <= 1'b1;
      match_q    <= 1'b0;
      tick_q     <= '0;
      hold_q     <= '0;
      ring_cnt_q <= '0;
      armed_q    <= 1'b0;
      ring_q     <= 1'b0;
      add_hour_q <= 1'b0;
      add_min_q  <= 1'b0;
      sw_clear_q <= 1'b0;
      state_q    <= S_WATCH;
    end else begin
      b0_sync_q  <= {b0_sync_q[0], b0};
      b1_sync_q  <= {b1_sync_q[0], b1};
      match_q    <= alarm_match;
      tick_q     <= tick ? '0 : tick_q + 1'b1;
      add_hour_q <= 1'b0;
      add_min_q  <= 1'b0;
      sw_clear_q <= 1'b0;
      if (tick) begin
        b0_smp_q <= b0_sync_q[1];
        b1_smp_q <= b1_sync_q[1];
        hold_q   <= held0 ? (rep0 ? hold_q : hold_q + 1'b1) : '0;
      end
      if (rise && armed_q) begin
        ring_q     <= 1'b1;
        ring_cnt_q <= '0;
      end else if (ring_q && (consume || !armed_q || ring_done)) begin
        ring_q <= 1'b0;
      end else if (ring_q && sec_tick) begin
        ring_cnt_q <= ring_cnt_q + 1'b1;
      end
      if (tick && !consume) begin
        case (state_q)
          S_WATCH:    state_q <= press0 ? S_SET : press1 ? S_ALARM : S_WATCH;
          S_SET:      state_q <= press0 ? S_WATCH : press1 ? S_SET_HOUR : S_SET;
          S_SET_HOUR: begin
            add_hour_q <= inc0;
            state_q    <= press1 ? S_SET_MIN : S_SET_HOUR;
          end
          S_SET_MIN:  begin
            add_min_q <= inc0;
            state_q   <= press1 ? S_SET : S_SET_MIN;
          end
          S_ALARM:    begin
            armed_q <= armed_q ^ press0;
            state_q <= press1 ? S_AL_HOUR : S_ALARM;
          end
          S_AL_HOUR:  begin
            add_hour_q <= inc0;
            state_q    <= press1 ? S_AL_MIN : S_AL_HOUR;
          end
          S_AL_MIN:   begin
            add_min_q <= inc0;
            state_q   <= press1 ? S_SW : S_AL_MIN;
          end
          S_SW:       state_q <= press0 ? S_SW_RUN : press1 ? S_WATCH : S_SW;
          S_SW_RUN:   state_q <= press0 ? S_SW_STOP : press1 ? S_SW_LAP : S_SW_RUN;
          S_SW_LAP:   state_q <= press0 ? S_SW_STOP : press1 ? S_SW_RUN : S_SW_LAP;
          S_SW_STOP:  begin
            sw_clear_q <= press1;
            state_q    <= press0 ? S_SW_RUN : press1 ? S_SW : S_SW_STOP;
          end
          default:    state_q <= S_WATCH;
        endcase
      end
    end
  end
  assign edit            = state_q inside {S_SET, S_SET_HOUR, S_SET_MIN};
  assign en_sec          = ~edit;
  assign en_min          = tc_sec & ~edit;
  assign en_hour         = tc_min & ~edit;
  assign sel_alarm       = state_q inside {S_AL_HOUR, S_AL_MIN};
  assign stopwatch       = state_q inside {S_SW, S_SW_STOP, S_SW_RUN, S_SW_LAP};
  assign stop_enable_sec = state_q inside {S_SW_RUN, S_SW_LAP};
  assign stop_enable_min = stopwatch_tc & stop_enable_sec;
  assign lap_hold        = state_q == S_SW_LAP;
  assign add_hour        = add_hour_q;
  assign add_min         = add_min_q;
  assign sw_clear        = sw_clear_q;
  assign alarm_armed     = armed_q;
  assign alarm_ring      = ring_q;
  assign state           = state_q;
endmodule
